// File: rtl/cp0_exc_if.sv
// Commit-stage request bundle and CP0 direct-write/redirect bundle for the exception sequencer.
interface cp0_exc_if #(
  parameter int N_INT = 6
);
  logic [31:0]      commit_pc;
  logic             commit_valid;
  logic             commit_bd;
  logic             exc_req;
  logic [4:0]       exc_code;
  logic             exc_has_bva;
  logic [31:0]      exc_bva;
  logic             eret_req;
  logic [N_INT-1:0] int_lines;
  logic [31:0]      cp0_status;
  logic [31:0]      cp0_cause;
  logic [31:0]      cp0_epc;

  logic [31:0]      in_epc;
  logic [31:0]      in_status;
  logic [31:0]      in_cause;
  logic [31:0]      in_badVAddr;
  logic             we_epc;
  logic             we_status;
  logic             we_cause;
  logic             we_badVAddr;
  logic             flush;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             busy;

  modport master (
    output commit_pc, commit_valid, commit_bd, exc_req, exc_code, exc_has_bva, exc_bva,
           eret_req, int_lines, cp0_status, cp0_cause, cp0_epc,
    input  in_epc, in_status, in_cause, in_badVAddr, we_epc, we_status, we_cause,
           we_badVAddr, flush, redirect, redirect_pc, busy
  );

  modport slave (
    input  commit_pc, commit_valid, commit_bd, exc_req, exc_code, exc_has_bva, exc_bva,
           eret_req, int_lines, cp0_status, cp0_cause, cp0_epc,
    output in_epc, in_status, in_cause, in_badVAddr, we_epc, we_status, we_cause,
           we_badVAddr, flush, redirect, redirect_pc, busy
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Exception/ERET sequencer: arbitrates interrupt, exception and ERET in IDLE, then runs a
// fixed save-then-jump sequence driving the CP0 direct-write ports and the fetch redirect.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int          N_INT      = 6
) (
  input  logic     clk,
  input  logic     res,
  cp0_exc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXC_SAVE, ERET_SAVE, JUMP} state_t;

  state_t      state;
  logic        int_pend;
  logic        exl;
  logic [31:0] epc_val;

  function automatic logic [31:0] build_cause(input logic [31:0]      cause,
                                              input logic [4:0]       code,
                                              input logic [N_INT-1:0] lines,
                                              input logic             exl_now,
                                              input logic             bd);
    logic [31:0] c;
    c              = cause;
    c[6:2]         = code;
    c[10 +: N_INT] = lines;
    // A nested exception leaves EPC alone, so BD must keep describing the original EPC.
    if (!exl_now) c[31] = bd;
    return c;
  endfunction

  always_comb begin
    exl      = bus.cp0_status[1];
    int_pend = (|(bus.int_lines & bus.cp0_status[10 +: N_INT])) & bus.cp0_status[0] & ~exl
               & bus.commit_valid;
    epc_val  = bus.commit_bd ? (bus.commit_pc - 32'd4) : bus.commit_pc;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state           <= IDLE;
      bus.busy        <= 1'b0;
      bus.flush       <= 1'b0;
      bus.redirect    <= 1'b0;
      bus.we_epc      <= 1'b0;
      bus.we_status   <= 1'b0;
      bus.we_cause    <= 1'b0;
      bus.we_badVAddr <= 1'b0;
      bus.in_epc      <= '0;
      bus.in_status   <= '0;
      bus.in_cause    <= '0;
      bus.in_badVAddr <= '0;
      bus.redirect_pc <= '0;
    end else begin
      bus.flush       <= 1'b0;
      bus.redirect    <= 1'b0;
      bus.we_epc      <= 1'b0;
      bus.we_status   <= 1'b0;
      bus.we_cause    <= 1'b0;
      bus.we_badVAddr <= 1'b0;
      unique case (state)
        // IDLE: sample and arbitrate; the winner's writes are registered straight into the save state
        IDLE: begin
          if (int_pend || bus.exc_req) begin
            state           <= EXC_SAVE;
            bus.busy        <= 1'b1;
            bus.flush       <= 1'b1;
            bus.we_cause    <= 1'b1;
            bus.in_cause    <= build_cause(bus.cp0_cause, int_pend ? 5'd0 : bus.exc_code,
                                           bus.int_lines, exl, bus.commit_bd);
            bus.we_status   <= 1'b1;
            bus.in_status   <= bus.cp0_status | 32'd2;
            bus.we_epc      <= ~exl;
            bus.in_epc      <= epc_val;
            bus.we_badVAddr <= ~int_pend & bus.exc_has_bva;
            bus.in_badVAddr <= int_pend ? 32'd0 : bus.exc_bva;
            bus.redirect_pc <= EXC_VECTOR;
          end else if (bus.eret_req) begin
            state           <= ERET_SAVE;
            bus.busy        <= 1'b1;
            bus.flush       <= 1'b1;
            bus.we_status   <= 1'b1;
            bus.in_status   <= bus.cp0_status & ~32'd2;
            bus.redirect_pc <= bus.cp0_epc;
          end
        end
        // SAVE: strobes are visible this cycle; schedule the fetch redirect
        EXC_SAVE, ERET_SAVE: begin
          state        <= JUMP;
          bus.redirect <= 1'b1;
        end
        // JUMP: redirect is visible this cycle; reopen for requests
        JUMP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed vector bench for cp0_exc_ctrl: table of request scenarios plus reset/hold sequences.
module tb_cp0_exc_ctrl;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  cp0_exc_if #(.N_INT(6)) bus();

  cp0_exc_ctrl #(.EXC_VECTOR(32'h8000_0180), .N_INT(6)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] status, cause, epc, pc;
    logic        bd, valid, exc;
    logic [4:0]  code;
    logic        has_bva;
    logic [31:0] bva;
    logic        eret;
    logic [5:0]  lines;
    logic        x_we_epc;
    logic [31:0] x_in_epc;
    logic        x_we_status;
    logic [31:0] x_in_status;
    logic        x_we_cause;
    logic [31:0] x_in_cause;
    logic        x_we_bva;
    logic [31:0] x_in_bva;
    logic [31:0] x_rpc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.commit_pc    = 32'h0;
    bus.commit_valid = 1'b1;
    bus.commit_bd    = 1'b0;
    bus.exc_req      = 1'b0;
    bus.exc_code     = 5'd0;
    bus.exc_has_bva  = 1'b0;
    bus.exc_bva      = 32'h0;
    bus.eret_req     = 1'b0;
    bus.int_lines    = 6'd0;
    bus.cp0_status   = 32'h0;
    bus.cp0_cause    = 32'h0;
    bus.cp0_epc      = 32'h0;
  endtask

  task automatic apply(input vec_t v);
    bus.cp0_status   = v.status;
    bus.cp0_cause    = v.cause;
    bus.cp0_epc      = v.epc;
    bus.commit_pc    = v.pc;
    bus.commit_bd    = v.bd;
    bus.commit_valid = v.valid;
    bus.exc_req      = v.exc;
    bus.exc_code     = v.code;
    bus.exc_has_bva  = v.has_bva;
    bus.exc_bva      = v.bva;
    bus.eret_req     = v.eret;
    bus.int_lines    = v.lines;
  endtask

  initial begin
    int n_redir;
    //          status         cause          epc            pc             bd   vld  exc  code   hbva bva            eret lines
    //          we_epc in_epc          we_st in_status     we_ca in_cause      we_bv in_bva          redirect_pc
    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0040_0010, 1'b0, 1'b1, 1'b1, 5'd4,  1'b1, 32'h1234_5679, 1'b0, 6'd0,
                1'b1, 32'h0040_0010, 1'b1, 32'h0000_0002, 1'b1, 32'h0000_0010, 1'b1, 32'h1234_5679, 32'h8000_0180};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0040_0014, 1'b1, 1'b1, 1'b1, 5'd4,  1'b1, 32'h1234_5679, 1'b0, 6'd0,
                1'b1, 32'h0040_0010, 1'b1, 32'h0000_0002, 1'b1, 32'h8000_0010, 1'b1, 32'h1234_5679, 32'h8000_0180};
    vecs[2] = '{32'h0000_0401, 32'h0000_0000, 32'h0000_0000, 32'h0040_0010, 1'b0, 1'b1, 1'b1, 5'd4,  1'b1, 32'h1234_5679, 1'b0, 6'd1,
                1'b1, 32'h0040_0010, 1'b1, 32'h0000_0403, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0000, 32'h8000_0180};
    vecs[3] = '{32'h0000_0403, 32'h8000_0000, 32'h0000_0000, 32'h0040_0010, 1'b0, 1'b1, 1'b1, 5'd4,  1'b1, 32'h1234_5679, 1'b0, 6'd1,
                1'b0, 32'h0000_0000, 1'b1, 32'h0000_0403, 1'b1, 32'h8000_0410, 1'b1, 32'h1234_5679, 32'h8000_0180};
    vecs[4] = '{32'h0000_0003, 32'h0000_0000, 32'h0040_0100, 32'h0040_0030, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 1'b1, 6'd0,
                1'b0, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0040_0100};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 32'h0000_0000, 1'b0, 6'd0,
                1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0002, 1'b1, 32'h8000_0030, 1'b0, 32'h0000_0000, 32'h8000_0180};
    vecs[6] = '{32'h0000_0001, 32'h0000_0000, 32'h0040_0300, 32'h0040_1000, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 32'h0000_0000, 1'b1, 6'd0,
                1'b1, 32'h0040_1000, 1'b1, 32'h0000_0003, 1'b1, 32'h0000_0028, 1'b0, 32'h0000_0000, 32'h8000_0180};
    vecs[7] = '{32'h0000_0401, 32'h0000_0000, 32'h0000_0000, 32'h0040_0020, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 32'h0000_0000, 1'b0, 6'd1,
                1'b1, 32'h0040_0020, 1'b1, 32'h0000_0403, 1'b1, 32'h0000_0420, 1'b0, 32'h0000_0000, 32'h8000_0180};
    vecs[8] = '{32'h0000_0400, 32'h0000_0000, 32'h0040_0200, 32'h0040_0040, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0000_0000, 1'b1, 6'd1,
                1'b0, 32'h0000_0000, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0040_0200};

    res = 1'b1;
    idle_inputs();
    step();
    step();
    check("rst.busy",        32'(bus.busy),        32'd0);
    check("rst.flush",       32'(bus.flush),       32'd0);
    check("rst.redirect",    32'(bus.redirect),    32'd0);
    check("rst.we_epc",      32'(bus.we_epc),      32'd0);
    check("rst.we_status",   32'(bus.we_status),   32'd0);
    check("rst.we_cause",    32'(bus.we_cause),    32'd0);
    check("rst.we_badVAddr", 32'(bus.we_badVAddr), 32'd0);
    check("rst.in_epc",      bus.in_epc,           32'd0);
    check("rst.in_status",   bus.in_status,        32'd0);
    check("rst.in_cause",    bus.in_cause,         32'd0);
    check("rst.in_badVAddr", bus.in_badVAddr,      32'd0);
    check("rst.redirect_pc", bus.redirect_pc,      32'd0);
    res = 1'b0;
    step();
    check("idle.busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i]);
      step();
      // Inputs change and new requests arrive while busy; none of it may matter.
      bus.cp0_epc    = 32'hDEAD_BEEF;
      bus.cp0_status = 32'hFFFF_FFFF;
      bus.cp0_cause  = 32'h5555_5555;
      bus.commit_pc  = 32'hCAFE_0000;
      bus.exc_req    = 1'b1;
      bus.eret_req   = 1'b1;
      bus.int_lines  = 6'h3F;
      check($sformatf("v%0d.flush", i),     32'(bus.flush),       32'd1);
      check($sformatf("v%0d.busy", i),      32'(bus.busy),        32'd1);
      check($sformatf("v%0d.redirect1", i), 32'(bus.redirect),    32'd0);
      check($sformatf("v%0d.we_epc", i),    32'(bus.we_epc),      32'(vecs[i].x_we_epc));
      check($sformatf("v%0d.we_status", i), 32'(bus.we_status),   32'(vecs[i].x_we_status));
      check($sformatf("v%0d.we_cause", i),  32'(bus.we_cause),    32'(vecs[i].x_we_cause));
      check($sformatf("v%0d.we_bva", i),    32'(bus.we_badVAddr), 32'(vecs[i].x_we_bva));
      check($sformatf("v%0d.in_status", i), bus.in_status,        vecs[i].x_in_status);
      if (vecs[i].x_we_epc)   check($sformatf("v%0d.in_epc", i),   bus.in_epc,      vecs[i].x_in_epc);
      if (vecs[i].x_we_cause) check($sformatf("v%0d.in_cause", i), bus.in_cause,    vecs[i].x_in_cause);
      if (vecs[i].x_we_bva)   check($sformatf("v%0d.in_bva", i),   bus.in_badVAddr, vecs[i].x_in_bva);
      step();
      idle_inputs();
      check($sformatf("v%0d.redirect", i),    32'(bus.redirect), 32'd1);
      check($sformatf("v%0d.redirect_pc", i), bus.redirect_pc,   vecs[i].x_rpc);
      check($sformatf("v%0d.jump_busy", i),   32'(bus.busy),     32'd1);
      check($sformatf("v%0d.jump_flush", i),  32'(bus.flush),    32'd0);
      check($sformatf("v%0d.jump_we", i),
            32'({bus.we_epc, bus.we_status, bus.we_cause, bus.we_badVAddr}), 32'd0);
      step();
      check($sformatf("v%0d.end_busy", i),     32'(bus.busy),     32'd0);
      check($sformatf("v%0d.end_redirect", i), 32'(bus.redirect), 32'd0);
    end

    // ERET held high across the whole sequence issues exactly one sequence.
    idle_inputs();
    bus.cp0_status = 32'h0000_0003;
    bus.cp0_epc    = 32'h0040_0100;
    bus.eret_req   = 1'b1;
    n_redir = 0;
    step();
    check("hold.busy_n1",   32'(bus.busy),      32'd1);
    check("hold.status_n1", bus.in_status,      32'h0000_0001);
    step();
    if (bus.redirect) n_redir++;
    check("hold.rpc_n2",    bus.redirect_pc,    32'h0040_0100);
    step();
    bus.eret_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.redirect) n_redir++;
      if (bus.busy) n_redir += 10;
      step();
    end
    check("hold.one_sequence", 32'(n_redir), 32'd1);

    // Reset in EXC_SAVE abandons the sequence before redirect.
    idle_inputs();
    bus.exc_req   = 1'b1;
    bus.exc_code  = 5'd4;
    bus.commit_pc = 32'h0040_0010;
    step();
    bus.exc_req = 1'b0;
    check("rsave.busy_n1", 32'(bus.busy), 32'd1);
    res = 1'b1;
    step();
    check("rsave.busy",  32'(bus.busy),  32'd0);
    check("rsave.flush", 32'(bus.flush), 32'd0);
    check("rsave.we",
          32'({bus.we_epc, bus.we_status, bus.we_cause, bus.we_badVAddr}), 32'd0);
    check("rsave.redirect_pc", bus.redirect_pc, 32'd0);
    res = 1'b0;
    n_redir = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.redirect) n_redir++;
      step();
    end
    check("rsave.no_redirect", 32'(n_redir), 32'd0);
    check("rsave.idle",        32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
